// File: rtl/temporizador.sv
// Microwave countdown timer: four BCD digits (MM:SS) loaded from the keypad,
// decremented once per TICK_DIV clocks while the magnetron is on.
module temporizador #(
    parameter int TICK_DIV = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       timer_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;

    // digits[0]=sec_ones .. digits[3]=min_tens
    logic [3:0][3:0] digits, digits_next, digits_dec;
    logic [PW-1:0]   pre, pre_next;
    state_t          state, state_next;

    logic count_zero, tick, load_ok;

    assign count_zero = (digits == '0);
    assign tick       = enable && !count_zero && (pre == PRE_MAX);
    assign load_ok    = load && !enable && (digit <= 4'd9);

    assign sec_ones   = digits[0];
    assign sec_tens   = digits[1];
    assign min_ones   = digits[2];
    assign min_tens   = digits[3];
    assign timer_done = count_zero;

    // BCD borrow chain; sec_tens may legally hold 6..9 after a keypad entry
    always_comb begin
        digits_dec = digits;
        if (digits[0] != 4'd0) begin
            digits_dec[0] = digits[0] - 4'd1;
        end else if (digits[1] != 4'd0) begin
            digits_dec[1] = digits[1] - 4'd1;
            digits_dec[0] = 4'd9;
        end else if (digits[2] != 4'd0) begin
            digits_dec[2] = digits[2] - 4'd1;
            digits_dec[1] = 4'd5;
            digits_dec[0] = 4'd9;
        end else if (digits[3] != 4'd0) begin
            digits_dec[3] = digits[3] - 4'd1;
            digits_dec[2] = 4'd9;
            digits_dec[1] = 4'd5;
            digits_dec[0] = 4'd9;
        end
    end

    always_comb begin
        digits_next = digits;
        pre_next    = '0;
        if (!clearn) begin
            digits_next = '0;
        end else if (tick) begin
            digits_next = digits_dec;
        end else if (load_ok) begin
            digits_next = {digits[2:0], digit};
        end
        // Partial second is dropped whenever the magnetron is off or count is 0
        if (clearn && enable && !count_zero && !tick) begin
            pre_next = pre + PW'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (!clearn) begin
            state_next = IDLE;
        end else if (tick) begin
            state_next = (digits_dec == '0) ? DONE : RUNNING;
        end else if (load_ok) begin
            state_next = ({digits[2:0], digit} == '0) ? IDLE : ARMED;
        end else if (!count_zero) begin
            state_next = enable ? RUNNING : ARMED;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digits <= '0;
            pre    <= '0;
            state  <= IDLE;
        end else begin
            digits <= digits_next;
            pre    <= pre_next;
            state  <= state_next;
        end
    end

endmodule

// File: tb/tb_temporizador.sv
// Directed bench for temporizador with TICK_DIV=4 and hand-computed MM:SS values.
module tb_temporizador;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       clearn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enable = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       timer_done;
    logic [15:0] t;

    int checks = 0;
    int errors = 0;

    temporizador #(.TICK_DIV(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .clearn     (clearn),
        .load       (load),
        .digit      (digit),
        .enable     (enable),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .timer_done (timer_done)
    );

    always #5 clock = ~clock;

    assign t = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        load  = 1'b1;
        digit = d;
        step();
        load  = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    initial begin
        // 1. reset
        step(2);
        resetn = 1'b1;
        step();
        chk("rst_time", t, 16'h0000);
        chk("rst_done", {15'd0, timer_done}, 16'd1);
        key(4'd1); key(4'd2);
        chk("pre_rst_load", t, 16'h0012);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_time", t, 16'h0000);
        chk("async_rst_done", {15'd0, timer_done}, 16'd1);
        #2 resetn = 1'b1;
        step();
        key(4'd1); key(4'd3); key(4'd0);
        chk("load_0130", t, 16'h0130);
        chk("load_0130_done", {15'd0, timer_done}, 16'd0);

        // 2. countdown to zero, no wrap
        clear();
        key(4'd3);
        enable = 1'b1;
        step(3);
        chk("cd_edge3", t, 16'h0003);
        step();
        chk("cd_edge4", t, 16'h0002);
        step(4);
        chk("cd_edge8", t, 16'h0001);
        step(3);
        chk("cd_edge11_done", {15'd0, timer_done}, 16'd0);
        step();
        chk("cd_edge12", t, 16'h0000);
        chk("cd_done", {15'd0, timer_done}, 16'd1);
        step(20);
        chk("cd_hold", t, 16'h0000);
        chk("cd_hold_done", {15'd0, timer_done}, 16'd1);
        enable = 1'b0;

        // 3. borrow chain
        clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        chk("load_1000", t, 16'h1000);
        enable = 1'b1;
        step(4);
        chk("borrow_0959", t, 16'h0959);
        step(4);
        chk("borrow_0958", t, 16'h0958);
        enable = 1'b0;
        clear();
        key(4'd1); key(4'd0); key(4'd0);
        enable = 1'b1;
        step(4);
        chk("borrow_0059", t, 16'h0059);
        enable = 1'b0;

        // 4. pause discards partial second
        clear();
        key(4'd5);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(3);
        chk("pause_hold", t, 16'h0005);
        enable = 1'b1;
        step(3);
        chk("resume_edge3", t, 16'h0005);
        step();
        chk("resume_edge4", t, 16'h0004);
        enable = 1'b0;

        // 5. ignored inputs
        clear();
        key(4'd7);
        enable = 1'b1;
        key(4'd3);
        chk("load_while_on", t, 16'h0007);
        enable = 1'b0;
        step();
        key(4'hA);
        chk("load_non_bcd", t, 16'h0007);
        clear();
        key(4'd0);
        chk("load_zero", t, 16'h0000);
        chk("load_zero_done", {15'd0, timer_done}, 16'd1);
        clearn = 1'b0;
        key(4'd6);
        clearn = 1'b1;
        chk("clear_beats_load", t, 16'h0000);
        key(4'd9); key(4'd0);
        chk("load_0090", t, 16'h0090);
        enable = 1'b1;
        step(4);
        chk("dec_0090", t, 16'h0089);
        enable = 1'b0;

        // 6. clear on a decrement edge
        clear();
        key(4'd5); key(4'd0); key(4'd0);
        enable = 1'b1;
        step(3);
        chk("run_0500", t, 16'h0500);
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        chk("clr_run_time", t, 16'h0000);
        chk("clr_run_done", {15'd0, timer_done}, 16'd1);
        enable = 1'b0;
        key(4'd2);
        chk("clr_reload", t, 16'h0002);
        enable = 1'b1;
        step(3);
        chk("clr_pre_edge3", t, 16'h0002);
        step();
        chk("clr_pre_edge4", t, 16'h0001);
        enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/temporizador.md
Name: temporizador

Overview:
Countdown timer for the microwave, holding MM:SS as four BCD digits. It is the source of timer_done for the magnetron control logic and the consumer of that logic's magnetron-on state.
- Keypad digits are shifted in while the magnetron is off.
- The count decrements once per second while enabled.
- timer_done is raised at 00:00 so the control logic drops the magnetron.

Parameters:
TICK_DIV, 10, clock cycles per one-second decrement; legal range 2..65535, prescaler width = clog2(TICK_DIV).

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
clearn  input  1  synchronous active-low clear; same button net as the control logic's clearn
load  input  1  one-cycle strobe: shift digit into the time register
digit  input  4  BCD keypad digit, sampled when load=1
enable  input  1  magnetron-on, from the control logic's set/reset latch
sec_ones  output  4  BCD seconds units
sec_tens  output  4  BCD seconds tens
min_ones  output  4  BCD minutes units
min_tens  output  4  BCD minutes tens
timer_done  output  1  high when all four digits are 0

Behaviour:
- resetn=0 (asynchronous, any time, including mid-countdown):
  - all digits 0, prescaler 0, state IDLE, timer_done=1.
  - On release, the block is in IDLE.
- timer_done is a decode of the digit registers: it is high in exactly the cycles where all digits are 0, with no added latency.
- States:
  - IDLE: count 00:00.
  - ARMED: count nonzero, enable=0.
  - RUNNING: count nonzero, enable=1.
  - DONE: reached 00:00 from RUNNING.
  - DONE and IDLE differ only for internal tracking; outputs are identical.
- Priority per rising edge: clearn=0 > decrement > load.
- Clear (clearn=0, any state):
  - digits and prescaler go to 0; next state IDLE.
  - timer_done=1 from the following cycle.
- Load (load=1, enable=0, clearn=1, digit<=9):
  - min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - The old min_tens is discarded.
  - Any BCD value is accepted in sec_tens, so 00:90 is legal.
  - Resulting state: ARMED if the new count is nonzero, else IDLE.
- load is ignored when:
  - digit>9, or
  - enable=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when enable=1 and the count is nonzero.
  - Forced to 0 in the same cycle whenever enable=0 or the count is 00:00.
  - A pause therefore discards the partial second.
- Decrement: occurs on the edge where prescaler=TICK_DIV-1 and enable=1; the prescaler wraps to 0.
  - The first decrement happens TICK_DIV edges after enable is first sampled high.
- BCD decrement rules:
  - sec_ones>0: sec_ones-1.
  - sec_ones=0, sec_tens>0: sec_tens-1, sec_ones=9.
  - seconds=00, min_ones>0: min_ones-1, seconds=59.
  - seconds=00, min_ones=0, min_tens>0: min_tens-1, min_ones=9, seconds=59.
  - 00:00: no decrement and no wrap; the count holds at 00:00 while enable stays high.
- Reaching 00:00 from RUNNING:
  - state DONE, timer_done=1.
  - The prescaler stays 0 until a new nonzero count is loaded.
- Simultaneous events:
  - load together with a decrement edge: the decrement wins and the load is dropped. This cannot arise in practice, since load requires enable=0.
  - clearn=0 with load=1: clear wins.
- enable falling mid-second: digits held, prescaler cleared, state ARMED.
- enable rising at 00:00: no effect; timer_done stays 1.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset: pulse resetn=0 asynchronously mid-cycle -> digits 0:0:0:0 immediately, timer_done=1; after release, load digits 1,3,0 -> 01:30, timer_done=0.
2. Countdown to zero: load 3 -> 00:03, enable=1 -> reads 00:02, 00:01, 00:00 at edges 4, 8, 12 after enable; timer_done=1 at 00:00; holding enable 20 more cycles -> still 00:00, no wrap.
3. Borrow chain: load 1,0,0,0 -> 10:00, enable=1 -> 09:59 after 4 edges, 09:58 after 8; load 1,0,0 -> 01:00 -> 00:59 after 4 edges.
4. Pause: 00:05 running, drop enable after 2 edges -> stays 00:05; re-raise enable -> 00:04 exactly 4 edges later, not 2.
5. Ignored inputs:
   - load=1 with enable=1 at 00:07 -> no shift.
   - digit=4'hA with load=1, enable=0 -> no shift.
   - load digit 0 into 00:00 -> stays IDLE, timer_done=1.
6. Clear during run: 05:00 running, clearn=0 for one cycle coincident with a decrement edge -> 00:00 at that edge, timer_done=1, prescaler 0; next load 2 -> 00:02.
